// File: rtl/l2_l1_fill_pkg.sv
// Shared widths, the URAM tag carried alongside read data, and small helpers
// for the L2->L1 fill engine.
package l2_l1_fill_pkg;
  localparam int L2_NSTRMS  = 16;
  localparam int L2_NCL     = 256;
  localparam int L1_NCL     = 16;
  localparam int DATA_WIDTH = 64;
  localparam int WAYS       = 8;
  localparam int BEATS      = 2;
  localparam int URAM_LAT   = 3;

  localparam int SID_W     = $clog2(L2_NSTRMS);
  localparam int L2PTR_W   = $clog2(L2_NCL);
  localparam int L1PTR_W   = $clog2(L1_NCL);
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PEND_W    = $clog2(L1_NCL) + 1;
  localparam int BEAT_BITS = WAYS * DATA_WIDTH;
  localparam int RA_W      = SID_W + L2PTR_W + BEAT_W;
  localparam int WA_W      = SID_W + L1PTR_W + BEAT_W;

  typedef struct packed {
    logic              v;
    logic [SID_W-1:0]  sid;
    logic [BEAT_W-1:0] beat;
    logic              last;
  } tag_t;

  function automatic logic [L1PTR_W-1:0] fptr_inc(input logic [L1PTR_W-1:0] p);
    return (p == L1PTR_W'(L1_NCL - 1)) ? '0 : p + 1'b1;
  endfunction

  // Drop a tag whose stream is being flushed this cycle.
  function automatic tag_t tag_kill(input tag_t t, input logic [L2_NSTRMS-1:0] flush);
    tag_t r;
    r = t;
    if (flush[t.sid]) r.v = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/l2_l1_fill_pend.sv
// Per-stream completed-line counter and L1 fill pointer.
// Flush wins over completion/response; a same-cycle inc+dec cancels out.
module l2_l1_fill_pend
  import l2_l1_fill_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               inc_i,
  input  logic               rsp_r_i,
  output logic               rsp_v_o,
  output logic [L1PTR_W-1:0] fptr_o
);
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [L1PTR_W-1:0] fptr_q, fptr_d;
  logic               dec;

  assign rsp_v_o = (pend_q != '0);
  assign dec     = rsp_v_o & rsp_r_i;
  assign fptr_o  = fptr_q;

  always_comb begin
    pend_d = pend_q;
    fptr_d = fptr_q;
    if (flush_i) begin
      pend_d = '0;
      fptr_d = '0;
    end else begin
      if (inc_i) fptr_d = fptr_inc(fptr_q);
      if (inc_i && !dec)      pend_d = pend_q + 1'b1;
      else if (!inc_i && dec) pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      fptr_q <= '0;
    end else begin
      pend_q <= pend_d;
      fptr_q <= fptr_d;
    end
  end

  // Upstream only requests into free L1 slots, so the count never passes L1_NCL.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec && !flush_i && pend_q == PEND_W'(L1_NCL)));
endmodule

// File: rtl/l2_l1_fill.sv
// Per-channel L2->L1 fill engine: issues URAM beat reads, tracks them in a tag
// pipe matched to URAM latency, writes beats into the L1 slot and signals completion.
module l2_l1_fill
  import l2_l1_fill_pkg::*;
(
  input  logic                          clk1x,
  input  logic                          reset,
  input  logic                          i_addr_v,
  output logic                          i_addr_r,
  input  logic [SID_W-1:0]              i_addr_sid,
  input  logic [L2PTR_W-1:0]            i_addr_ptr,
  output logic                          o_uram_re,
  output logic [RA_W-1:0]               o_uram_ra,
  input  logic [BEAT_BITS-1:0]          i_uram_d,
  output logic                          o_we,
  output logic [WA_W-1:0]               o_wa,
  output logic [BEAT_BITS-1:0]          o_wd,
  input  logic [L2_NSTRMS-1:0]          i_rst_v,
  output logic [L2_NSTRMS-1:0]          o_rsp_v,
  input  logic [L2_NSTRMS-1:0]          o_rsp_r
);
  // Issue state: beat_cnt_q = beats still to issue after the current one (0 = idle).
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d, nbeat_q, nbeat_d;
  logic [SID_W-1:0]   sid_q, sid_d;
  logic [L2PTR_W-1:0] ptr_q, ptr_d;
  logic               live_q, live_d;
  logic               re_q, re_d;
  logic [RA_W-1:0]    ra_q, ra_d;
  tag_t               tag_new;

  tag_t [URAM_LAT:0]  pipe_q;
  tag_t               wtag;
  logic               we_q, we_d, wlast_q;
  logic [WA_W-1:0]    wa_q, wa_d;
  logic [BEAT_BITS-1:0] wd_q;
  logic [SID_W-1:0]   wsid;
  logic               cmp;
  logic [L1PTR_W-1:0] wptr;

  logic [L2_NSTRMS-1:0][L1PTR_W-1:0] fptr;
  logic [L2_NSTRMS-1:0]              inc;

  assign i_addr_r  = ~reset & (beat_cnt_q == '0);
  assign o_uram_re = re_q;
  assign o_uram_ra = ra_q;
  assign o_we      = we_q;
  assign o_wa      = wa_q;
  assign o_wd      = wd_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    nbeat_d    = nbeat_q;
    sid_d      = sid_q;
    ptr_d      = ptr_q;
    live_d     = live_q;
    re_d       = 1'b0;
    ra_d       = ra_q;
    tag_new    = '0;
    if (beat_cnt_q == '0) begin
      if (i_addr_v && i_addr_r) begin
        re_d         = 1'b1;
        ra_d         = {i_addr_sid, i_addr_ptr, BEAT_W'(0)};
        beat_cnt_d   = BEAT_W'(BEATS - 1);
        nbeat_d      = BEAT_W'(1);
        sid_d        = i_addr_sid;
        ptr_d        = i_addr_ptr;
        live_d       = 1'b1;
        tag_new.v    = 1'b1;
        tag_new.sid  = i_addr_sid;
        tag_new.last = (BEATS == 1);
      end
    end else begin
      // A flushed line keeps reading its remaining beats, tagged dead.
      re_d         = 1'b1;
      ra_d         = {sid_q, ptr_q, nbeat_q};
      live_d       = live_q & ~i_rst_v[sid_q];
      beat_cnt_d   = beat_cnt_q - 1'b1;
      nbeat_d      = nbeat_q + 1'b1;
      tag_new.v    = live_d;
      tag_new.sid  = sid_q;
      tag_new.beat = nbeat_q;
      tag_new.last = (beat_cnt_q == BEAT_W'(1));
    end
  end

  // Completion of the line in the write stage bumps fptr at this edge; forward it
  // so a back-to-back line to the same stream lands in the next slot.
  assign wtag = pipe_q[URAM_LAT];
  assign wsid = wa_q[WA_W-1 -: SID_W];
  assign cmp  = we_q & wlast_q;
  assign wptr = (cmp && wsid == wtag.sid) ? fptr_inc(fptr[wtag.sid]) : fptr[wtag.sid];
  assign we_d = wtag.v & ~i_rst_v[wtag.sid];
  assign wa_d = {wtag.sid, wptr, wtag.beat};

  always_ff @(posedge clk1x) begin
    if (reset) begin
      beat_cnt_q <= '0;
      nbeat_q    <= '0;
      sid_q      <= '0;
      ptr_q      <= '0;
      live_q     <= 1'b0;
      re_q       <= 1'b0;
      ra_q       <= '0;
      pipe_q     <= '0;
      we_q       <= 1'b0;
      wlast_q    <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      nbeat_q    <= nbeat_d;
      sid_q      <= sid_d;
      ptr_q      <= ptr_d;
      live_q     <= live_d;
      re_q       <= re_d;
      ra_q       <= ra_d;
      pipe_q[0]  <= tag_kill(tag_new, i_rst_v);
      for (int k = 1; k <= URAM_LAT; k++) pipe_q[k] <= tag_kill(pipe_q[k-1], i_rst_v);
      we_q       <= we_d;
      if (we_d) begin
        wa_q    <= wa_d;
        wd_q    <= i_uram_d;
        wlast_q <= wtag.last;
      end
    end
  end

  for (genvar s = 0; s < L2_NSTRMS; s++) begin : g_strm
    assign inc[s] = cmp & (wsid == SID_W'(s));
    l2_l1_fill_pend u_pend (
      .clk_i   (clk1x),
      .rst_i   (reset),
      .flush_i (i_rst_v[s]),
      .inc_i   (inc[s]),
      .rsp_r_i (o_rsp_r[s]),
      .rsp_v_o (o_rsp_v[s]),
      .fptr_o  (fptr[s])
    );
  end

  a_no_req_on_flush: assert property (@(posedge clk1x) disable iff (reset)
    !(i_addr_v && i_rst_v[i_addr_sid]));
endmodule
